axi4_slave_mem_responder: RTL and testbench
===========================================

Name: axi4_slave_mem_responder

Overview:
- Synthesizable AXI4 slave memory that answers AXI master traffic in the `chip` block design; the responder end of the master-initiated protocol.
- Independent write path (AW/W/B) and read path (AR/R).
- INCR bursts, full data width per beat, single outstanding transaction per direction.
- Backing store is an on-chip word array; it replaces simulation-only slave models in system-level runs.

Parameters:
- ADDR_WIDTH, 12, byte-address width.
- DATA_WIDTH, 32, data bus width; must be 32 or 64.
- MEM_DEPTH, 1024, number of DATA_WIDTH words; must be <= 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).

Ports:
aclk  in  1  clock; all logic rising-edge.
aresetn  in  1  reset, asynchronous, active-low.
s_axi_awaddr  in  ADDR_WIDTH  write burst start byte address.
s_axi_awlen  in  8  write beats minus 1.
s_axi_awvalid  in  1  AW valid.
s_axi_awready  out  1  AW ready.
s_axi_wdata  in  DATA_WIDTH  write data.
s_axi_wstrb  in  DATA_WIDTH/8  byte enables.
s_axi_wlast  in  1  last write beat.
s_axi_wvalid  in  1  W valid.
s_axi_wready  out  1  W ready.
s_axi_bresp  out  2  write response.
s_axi_bvalid  out  1  B valid.
s_axi_bready  in  1  B ready.
s_axi_araddr  in  ADDR_WIDTH  read burst start byte address.
s_axi_arlen  in  8  read beats minus 1.
s_axi_arvalid  in  1  AR valid.
s_axi_arready  out  1  AR ready.
s_axi_rdata  out  DATA_WIDTH  read data.
s_axi_rresp  out  2  read response.
s_axi_rlast  out  1  last read beat.
s_axi_rvalid  out  1  R valid.
s_axi_rready  in  1  R ready.

Behaviour:
- Reset values: all ready/valid outputs, rlast, bresp, rresp and rdata are 0. Memory contents are not cleared.
- awready and arready rise on the first clock after aresetn deasserts.
- Handshake occurs when valid && ready on a rising edge. Every output is held stable while valid && !ready.
- Word index = addr >> log2(DATA_WIDTH/8); unaligned low bits are ignored. Each beat adds 1 to the index.
- Beat out of range (index >= MEM_DEPTH): no write, read returns 0, response is SLVERR (2'b10). In-range beats return OKAY (2'b00). Range is checked per beat.
- Write FSM:
  - W_IDLE: awready=1. AW handshake latches addr/len, goes to W_DATA.
  - W_DATA: wready=1. Each beat writes the bytes enabled by wstrb. Beat counter counts up. On the beat with wlast=1, goes to W_RESP.
  - W_RESP: bvalid=1 on the cycle after the last W handshake. bresp = SLVERR if any beat was out of range, or if wlast position != awlen+1; otherwise OKAY. B handshake returns to W_IDLE.
  - Missing wlast: once awlen+1 beats are taken, keep accepting beats until wlast arrives, discarding the extra data; response is SLVERR.
  - Maximum write throughput is one beat per cycle.
- Read FSM:
  - R_IDLE: arready=1. AR handshake at cycle T latches addr/len, goes to R_DATA.
  - R_DATA: first rvalid at T+2 (synchronous array read plus output register). With rready held high, beats follow every cycle; a 2-entry output skid buffer keeps this true under backpressure.
  - rlast=1 only on beat arlen+1. The R handshake of the last beat returns to R_IDLE; arready is 1 the next cycle.
- Read and write on the same word in the same cycle: read returns the old data (read-first).
- A burst crossing MEM_DEPTH continues counting; the beats past the end take the out-of-range rule.
- aresetn assertion mid-burst: both FSMs go to idle immediately, outputs take their reset values, and the partial burst is abandoned. Words already written stay written.

Decomposition:
- Package axi4_slave_mem_pkg holds: RESP_OKAY=2'b00, RESP_SLVERR=2'b10; wr_state_t {W_IDLE,W_DATA,W_RESP}; rd_state_t {R_IDLE,R_DATA}; function for the word-index shift.
- Sub-module axi4_slave_mem_array: simple dual-port array, write port with byte enables, synchronous read port with read-first collision behaviour.

Test Plan:
- Single write 0xDEADBEEF @0x004, wstrb=0xF; then read @0x004 -> bresp=0, rdata=0xDEADBEEF, rlast=1, rresp=0.
- Burst write awlen=3 @0x010 data 1,2,3,4, beat 2 wstrb=0x3; read arlen=3 with rready high -> 1, (old[31:16] merged with 0x0002), 3, 4 on 4 consecutive cycles, rlast on beat 4, first rvalid at T+2.
- Read burst arlen=7 with rready toggling 1/0 every cycle -> rdata/rlast held stable while stalled, 8 beats delivered in order, no loss or duplication.
- Write @ word MEM_DEPTH-1 with awlen=1 -> first beat stored, second beat dropped, bresp=2'b10. Same read -> beat 2 rdata=0, rresp=2'b10.
- awlen=3 with wlast on beat 2 -> bresp=2'b10, FSM back in W_IDLE, next single write returns OKAY.
- aresetn pulled low during beat 3 of an 8-beat read -> rvalid=0 immediately; after release arready=1 next cycle and a new read completes correctly.

Source files
------------

// File: rtl/axi4_slave_mem_pkg.sv
// Shared types and helpers for the AXI4 slave memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi4_slave_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Byte address to word index; only 32- and 64-bit buses are legal.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int unsigned data_width);
    return (data_width == 64) ? (addr >> 3) : (addr >> 2);
  endfunction

endpackage

// File: rtl/axi4_slave_mem_responder_if.sv
// AXI4 write/read channel bundle between a master and the memory responder.
// Latency: none, wires only.
// Backpressure: valid/ready per channel; the responder drives the ready side of AW/W/AR.
interface axi4_slave_mem_responder_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arlen, arvalid, input arready,
    input  rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awaddr, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arlen, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/axi4_slave_mem_array.sv
// Simple dual-port word array: byte-enabled write port, registered read port, read-first on collision.
// Latency: read data valid one clock after re.
// Backpressure: none; the caller only issues a read when it has room for the result.
module axi4_slave_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int AW         = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    re,
  input  logic [AW-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Both ports in one process with non-blocking writes gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axi4_slave_mem_responder.sv
// AXI4 slave memory: INCR bursts, one outstanding transaction per direction, per-beat range check.
// Latency: B one clock after the last W beat; first R beat two clocks after the AR handshake.
// Backpressure: R uses a 2-entry output skid so beats stay one per clock under rready stalls.
module axi4_slave_mem_responder
  import axi4_slave_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  axi4_slave_mem_responder_if.slave     s_axi
);

  localparam int          MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] DEPTH  = 32'(MEM_DEPTH);

  // Holds the address-channel readies low until the first clock after reset release.
  logic ready_en;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  wr_state_t             w_state, w_state_nxt;
  logic [31:0]           w_idx;
  logic [7:0]            w_len;
  logic [8:0]            w_cnt;
  logic                  w_err;
  logic                  aw_hs, w_hs, b_hs;
  logic                  w_extra, w_oor, w_beat_err, mem_we;

  assign aw_hs      = s_axi.awvalid && s_axi.awready;
  assign w_hs       = s_axi.wvalid && s_axi.wready;
  assign b_hs       = s_axi.bvalid && s_axi.bready;
  assign w_extra    = w_cnt > {1'b0, w_len};
  assign w_oor      = w_idx >= DEPTH;
  assign w_beat_err = w_extra || w_oor || (s_axi.wlast && (w_cnt != {1'b0, w_len}));
  assign mem_we     = w_hs && !w_extra && !w_oor;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && s_axi.wlast) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    s_axi.bresp   = RESP_OKAY;
    case (w_state)
      W_IDLE: s_axi.awready = ready_en;
      W_DATA: s_axi.wready  = 1'b1;
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        s_axi.bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

  // Beats past awlen+1 are still accepted until wlast, but never written.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (aw_hs) begin
      w_idx <= word_index(32'(s_axi.awaddr), DATA_WIDTH);
      w_len <= s_axi.awlen;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (w_hs) begin
      w_idx <= w_idx + 32'd1;
      if (w_cnt != '1) w_cnt <= w_cnt + 9'd1;
      w_err <= w_err | w_beat_err;
    end
  end

  rd_state_t             r_state, r_state_nxt;
  logic [31:0]           r_idx;
  logic [7:0]            r_len;
  logic [8:0]            r_cnt;
  logic                  ar_hs, r_hs, issue;
  logic [2:0]            occ;
  logic                  p_vld, p_err, p_last;
  logic [DATA_WIDTH-1:0] arr_rdata, p_dat;
  logic                  o_vld, o_err, o_last;
  logic [DATA_WIDTH-1:0] o_dat;
  logic                  s_vld, s_err, s_last;
  logic [DATA_WIDTH-1:0] s_dat;

  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign r_hs  = s_axi.rvalid && s_axi.rready;
  // Beats in the array stage plus the two holding slots, net of this cycle's drain.
  assign occ   = 3'(p_vld) + 3'(o_vld) + 3'(s_vld) - 3'(r_hs);
  assign issue = (r_state == R_DATA) && (r_cnt <= {1'b0, r_len}) && (occ < 3'd2);
  assign p_dat = p_err ? '0 : arr_rdata;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && s_axi.rlast) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = (r_state == R_IDLE) && ready_en;
    s_axi.rvalid  = o_vld;
    s_axi.rdata   = o_dat;
    s_axi.rlast   = o_last;
    s_axi.rresp   = o_err ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_idx  <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      p_vld  <= 1'b0;
      p_err  <= 1'b0;
      p_last <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_idx <= word_index(32'(s_axi.araddr), DATA_WIDTH);
        r_len <= s_axi.arlen;
        r_cnt <= '0;
      end else if (issue) begin
        r_idx <= r_idx + 32'd1;
        r_cnt <= r_cnt + 9'd1;
      end
      p_vld  <= issue;
      p_err  <= r_idx >= DEPTH;
      p_last <= r_cnt == {1'b0, r_len};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      o_vld  <= 1'b0;
      o_err  <= 1'b0;
      o_last <= 1'b0;
      o_dat  <= '0;
      s_vld  <= 1'b0;
      s_err  <= 1'b0;
      s_last <= 1'b0;
      s_dat  <= '0;
    end else if (!o_vld || r_hs) begin
      if (s_vld) begin
        o_vld  <= 1'b1;
        o_err  <= s_err;
        o_last <= s_last;
        o_dat  <= s_dat;
        s_vld  <= p_vld;
        s_err  <= p_vld && p_err;
        s_last <= p_vld && p_last;
        if (p_vld) s_dat <= p_dat;
      end else begin
        o_vld  <= p_vld;
        o_err  <= p_vld && p_err;
        o_last <= p_vld && p_last;
        if (p_vld) o_dat <= p_dat;
      end
    end else if (p_vld) begin
      s_vld  <= 1'b1;
      s_err  <= p_err;
      s_last <= p_last;
      s_dat  <= p_dat;
    end
  end

  axi4_slave_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .AW         (MEM_AW)
  ) u_array (
    .clk   (aclk),
    .we    (mem_we),
    .waddr (w_idx[MEM_AW-1:0]),
    .wdata (s_axi.wdata),
    .wstrb (s_axi.wstrb),
    .re    (issue),
    .raddr (r_idx[MEM_AW-1:0]),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_axi4_slave_mem_responder.sv
// Scoreboard bench for the AXI4 slave memory responder.
module tb_axi4_slave_mem_responder;
  import axi4_slave_mem_pkg::*;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int TO    = 300;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4_slave_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_axi();

  axi4_slave_mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi   (s_axi)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  resp;
    logic        last;
    logic        first;
  } rbeat_t;

  rbeat_t      r_q[$];
  logic [1:0]  b_q[$];
  logic [31:0] model [DEPTH];
  rbeat_t      exp_r;
  logic [1:0]  exp_b;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int ar_cyc       = 0;
  int last_r_cyc   = 0;
  bit first_pend   = 0;
  bit gap_chk      = 0;
  bit stall_pend   = 0;
  logic [31:0] stall_dat;
  logic        stall_last;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (stall_pend) begin
        check("r_hold_vld", s_axi.rvalid, 1);
        check("r_hold_dat", s_axi.rdata, stall_dat);
        check("r_hold_last", s_axi.rlast, stall_last);
        stall_pend = 0;
      end
      if (s_axi.rvalid && first_pend) begin
        check("r_latency", cyc - ar_cyc, 2);
        first_pend = 0;
      end
      if (s_axi.arvalid && s_axi.arready) begin
        ar_cyc     = cyc + 1;
        first_pend = 1;
      end
      if (s_axi.rvalid && s_axi.rready) begin
        if (r_q.size() == 0) check("r_unexpected", s_axi.rvalid, 0);
        else begin
          exp_r = r_q.pop_front();
          check("rdata", s_axi.rdata, exp_r.dat);
          check("rresp", s_axi.rresp, exp_r.resp);
          check("rlast", s_axi.rlast, exp_r.last);
          if (gap_chk && !exp_r.first) check("r_gap", cyc - last_r_cyc, 1);
          last_r_cyc = cyc;
        end
      end else if (s_axi.rvalid) begin
        stall_pend = 1;
        stall_dat  = s_axi.rdata;
        stall_last = s_axi.rlast;
      end
      if (s_axi.bvalid && s_axi.bready) begin
        if (b_q.size() == 0) check("b_unexpected", s_axi.bvalid, 0);
        else begin
          exp_b = b_q.pop_front();
          check("bresp", s_axi.bresp, exp_b);
        end
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len, input int nbeats,
                          input logic [31:0] base, input int sp_beat, input logic [3:0] sp_strb);
    logic [31:0] idx;
    logic [31:0] d;
    logic [3:0]  st;
    logic        err;
    int          n;
    idx = 32'(addr) >> 2;
    err = (nbeats != int'(len) + 1);
    for (int i = 0; i < nbeats; i++) begin
      d  = base + 32'(i);
      st = (i == sp_beat) ? sp_strb : 4'hF;
      if (i <= int'(len)) begin
        if (idx + 32'(i) >= 32'(DEPTH)) err = 1'b1;
        else for (int b = 0; b < 4; b++) if (st[b]) model[idx + 32'(i)][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    b_q.push_back(err ? 2'b10 : 2'b00);
    s_axi.awaddr  = addr;
    s_axi.awlen   = len;
    s_axi.awvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!s_axi.awready && n < TO);
    if (!s_axi.awready) check("aw_timeout", s_axi.awready, 1);
    @(posedge aclk); #1;
    s_axi.awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      s_axi.wdata  = base + 32'(i);
      s_axi.wstrb  = (i == sp_beat) ? sp_strb : 4'hF;
      s_axi.wlast  = (i == nbeats - 1);
      s_axi.wvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!s_axi.wready && n < TO);
      if (!s_axi.wready) check("w_timeout", s_axi.wready, 1);
      @(posedge aclk); #1;
    end
    s_axi.wvalid = 1'b0;
    s_axi.wlast  = 1'b0;
    n = 0;
    while (b_q.size() != 0 && n < TO) begin @(posedge aclk); #1; n++; end
    if (b_q.size() != 0) check("b_timeout", b_q.size(), 0);
  endtask

  task automatic rd_start(input logic [AW-1:0] addr, input logic [7:0] len);
    logic [31:0] idx;
    rbeat_t      bt;
    int          n;
    idx = 32'(addr) >> 2;
    for (int i = 0; i <= int'(len); i++) begin
      if (idx + 32'(i) < 32'(DEPTH)) begin
        bt.dat  = model[idx + 32'(i)];
        bt.resp = 2'b00;
      end else begin
        bt.dat  = 32'h0;
        bt.resp = 2'b10;
      end
      bt.last  = (i == int'(len));
      bt.first = (i == 0);
      r_q.push_back(bt);
    end
    s_axi.araddr  = addr;
    s_axi.arlen   = len;
    s_axi.arvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!s_axi.arready && n < TO);
    if (!s_axi.arready) check("ar_timeout", s_axi.arready, 1);
    @(posedge aclk); #1;
    s_axi.arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input bit toggle);
    int n;
    gap_chk      = !toggle;
    s_axi.rready = 1'b1;
    rd_start(addr, len);
    n = 0;
    while (r_q.size() != 0 && n < TO) begin
      @(posedge aclk); #1;
      if (toggle) s_axi.rready = ~s_axi.rready;
      n++;
    end
    if (r_q.size() != 0) check("r_timeout", r_q.size(), 0);
    s_axi.rready = 1'b1;
    @(posedge aclk); #1;
  endtask

  initial begin
    int n;
    s_axi.awaddr  = '0;
    s_axi.awlen   = '0;
    s_axi.awvalid = 1'b0;
    s_axi.wdata   = '0;
    s_axi.wstrb   = '0;
    s_axi.wlast   = 1'b0;
    s_axi.wvalid  = 1'b0;
    s_axi.bready  = 1'b1;
    s_axi.araddr  = '0;
    s_axi.arlen   = '0;
    s_axi.arvalid = 1'b0;
    s_axi.rready  = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", s_axi.awready, 0);
    check("rst_wready",  s_axi.wready,  0);
    check("rst_bvalid",  s_axi.bvalid,  0);
    check("rst_bresp",   s_axi.bresp,   0);
    check("rst_arready", s_axi.arready, 0);
    check("rst_rvalid",  s_axi.rvalid,  0);
    check("rst_rlast",   s_axi.rlast,   0);
    check("rst_rresp",   s_axi.rresp,   0);
    check("rst_rdata",   s_axi.rdata,   0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("pre_clk_awready", s_axi.awready, 0);
    check("pre_clk_arready", s_axi.arready, 0);
    @(posedge aclk); #1;
    check("post_rst_awready", s_axi.awready, 1);
    check("post_rst_arready", s_axi.arready, 1);

    // single write and read back
    do_write(12'h004, 8'd0, 1, 32'hDEAD_BEEF, -1, 4'hF);
    do_read(12'h004, 8'd0, 1'b0);

    // burst with partial strobe merging over known old data
    do_write(12'h010, 8'd3, 4, 32'hAAAA_0000, -1, 4'hF);
    do_write(12'h010, 8'd3, 4, 32'h0000_0001, 1, 4'h3);
    do_read(12'h010, 8'd3, 1'b0);

    // 8-beat read under toggling backpressure
    do_write(12'h100, 8'd7, 8, 32'h5000_0000, -1, 4'hF);
    do_read(12'h100, 8'd7, 1'b1);

    // burst crossing the end of memory
    do_write(12'hFFC, 8'd1, 2, 32'h1234_5670, -1, 4'hF);
    do_read(12'hFFC, 8'd1, 1'b0);

    // early wlast, then a clean single write
    do_write(12'h040, 8'd3, 2, 32'h7700_0000, -1, 4'hF);
    check("w_idle_after_err", s_axi.awready, 1);
    do_write(12'h048, 8'd0, 1, 32'h0000_0099, -1, 4'hF);
    do_read(12'h040, 8'd2, 1'b0);

    // missing wlast: extra beats must not land in the next word
    do_write(12'h084, 8'd0, 1, 32'h0000_0044, -1, 4'hF);
    do_write(12'h080, 8'd0, 3, 32'h3300_0000, -1, 4'hF);
    do_read(12'h080, 8'd1, 1'b0);

    // reset in the middle of an 8-beat read
    do_write(12'h200, 8'd7, 8, 32'h6600_0000, -1, 4'hF);
    gap_chk      = 1'b1;
    s_axi.rready = 1'b1;
    rd_start(12'h200, 8'd7);
    n = 0;
    while (r_q.size() > 6 && n < TO) begin @(posedge aclk); #1; n++; end
    check("beat3_shown", s_axi.rvalid, 1);
    aresetn = 1'b0;
    #1;
    check("mid_rst_rvalid",  s_axi.rvalid,  0);
    check("mid_rst_rlast",   s_axi.rlast,   0);
    check("mid_rst_rdata",   s_axi.rdata,   0);
    check("mid_rst_arready", s_axi.arready, 0);
    r_q.delete();
    stall_pend = 0;
    first_pend = 0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel_pre_arready", s_axi.arready, 0);
    @(posedge aclk); #1;
    check("rel_arready", s_axi.arready, 1);
    do_read(12'h200, 8'd7, 1'b0);
    do_read(12'h004, 8'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
